// File: rtl/button_pkg.sv
// Shared definitions for the button gesture classifier: FSM state
// encoding and the width helper for the shared timeout counter.
package button_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESS1    = 3'd1;
    localparam logic [2:0] WAIT_GAP  = 3'd2;
    localparam logic [2:0] PRESS2    = 3'd3;
    localparam logic [2:0] LONG_HELD = 3'd4;

    // One counter serves every timeout, so it is sized for the largest one.
    function automatic int cnt_width(input int long_c, input int gap_c, input int rep_c);
        int m;
        m = long_c;
        if (gap_c > m) m = gap_c;
        if (rep_c > m) m = rep_c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_gesture_if.sv
// Debounced edge pulses in, gesture pulses and hold level out.
interface button_gesture_if;

    logic rise;
    logic fall;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_press;
    logic hold;

    // Upstream side: debounce pulses out, gestures in.
    modport master (
        output rise, fall,
        input  short_press, double_press, long_press, repeat_press, hold
    );

    // Classifier side.
    modport slave (
        input  rise, fall,
        output short_press, double_press, long_press, repeat_press, hold
    );

endinterface

// File: rtl/button_gesture.sv
// Classifies debounced press/release pulses into short, double, long and
// auto-repeat gesture pulses plus a hold level. One FSM, one shared counter.
module button_gesture
    import button_pkg::*;
#(
    parameter int LONG_COUNT   = 50_000_000,
    parameter int GAP_COUNT    = 15_000_000,
    parameter int REPEAT_COUNT = 10_000_000
) (
    input  logic            clock,
    input  logic            reset_n,
    button_gesture_if.slave btn
);

    localparam int CW = cnt_width(LONG_COUNT, GAP_COUNT, REPEAT_COUNT);

    // Terminal values are one below the count: the counter starts at 0 on
    // the edge that enters the state, so value N-1 is seen at edge N.
    localparam logic [CW-1:0] LONG_TERM = CW'(LONG_COUNT - 1);
    localparam logic [CW-1:0] GAP_TERM  = CW'(GAP_COUNT - 1);
    localparam logic [CW-1:0] REP_TERM  = CW'((REPEAT_COUNT > 0) ? REPEAT_COUNT - 1 : 0);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic          reload;
    logic          counting;

    logic short_q,  short_nxt;
    logic double_q, double_nxt;
    logic long_q,   long_nxt;
    logic repeat_q, repeat_nxt;
    logic hold_q,   hold_nxt;

    // Simultaneous rise and fall is an upstream protocol error: neither counts.
    logic rise_ev;
    logic fall_ev;
    assign rise_ev = btn.rise & ~btn.fall;
    assign fall_ev = btn.fall & ~btn.rise;

    // Next state and gesture decisions; input events take priority over timeouts.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        hold_nxt   = hold_q;
        reload     = 1'b0;
        case (state)
            IDLE: begin
                // A release here (e.g. after reset mid-press) is ignored.
                if (rise_ev) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (fall_ev) begin
                    state_nxt = WAIT_GAP;
                end else if (cnt == LONG_TERM) begin
                    long_nxt  = 1'b1;
                    hold_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end
            end
            WAIT_GAP: begin
                if (rise_ev) begin
                    double_nxt = 1'b1;
                    state_nxt  = PRESS2;
                end else if (cnt == GAP_TERM) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESS2: begin
                // The second press of a double is never promoted to long.
                if (fall_ev) state_nxt = IDLE;
            end
            LONG_HELD: begin
                if (fall_ev) begin
                    hold_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (REPEAT_COUNT > 0 && cnt == REP_TERM) begin
                    repeat_nxt = 1'b1;
                    reload     = 1'b1;
                end
            end
            default: begin
                hold_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // The counter only runs in timed states; with repeat disabled it stays
    // at 0 in LONG_HELD so it can never wrap.
    always_comb begin
        counting = (state == PRESS1) || (state == WAIT_GAP) ||
                   ((state == LONG_HELD) && (REPEAT_COUNT > 0));
    end

    // State register and shared counter, cleared on every state change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state <= state_nxt;
            if (state_nxt != state || reload) begin
                cnt <= '0;
            end else if (counting) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered gesture pulses and hold level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            short_q  <= short_nxt;
            double_q <= double_nxt;
            long_q   <= long_nxt;
            repeat_q <= repeat_nxt;
            hold_q   <= hold_nxt;
        end
    end

    assign btn.short_press  = short_q;
    assign btn.double_press = double_q;
    assign btn.long_press   = long_q;
    assign btn.repeat_press = repeat_q;
    assign btn.hold         = hold_q;

endmodule

// File: tb/tb_button_gesture.sv
// Self-checking bench for button_gesture with LONG=8, GAP=5, REPEAT=4.
// Output vector order everywhere: {short, double, long, repeat, hold}.
module tb_button_gesture;

    logic clock;
    logic reset_n;

    button_gesture_if bif ();

    button_gesture #(
        .LONG_COUNT  (8),
        .GAP_COUNT   (5),
        .REPEAT_COUNT(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .btn    (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One scenario: edges of input pulses and edges where each output is
    // expected high (-1 = unused). hold is high after edges [hold_lo, hold_hi).
    typedef struct {
        int rise_a; int rise_b;
        int fall_a; int fall_b;
        int both_e;
        int ncyc;
        int short_a; int short_b;
        int dbl_e;
        int long_e;
        int rep_a; int rep_b;
        int hold_lo; int hold_hi;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    logic [4:0] exp_q [$];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [4:0] dut_out();
        return {bif.short_press, bif.double_press, bif.long_press,
                bif.repeat_press, bif.hold};
    endfunction

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Drive one edge's inputs, queue its expected outputs, compare after the edge.
    task automatic step(input string nm, input logic r, input logic f, input logic [4:0] exp);
        logic [4:0] e;
        bif.rise = r;
        bif.fall = f;
        exp_q.push_back(exp);
        @(posedge clock);
        @(negedge clock);
        bif.rise = 1'b0;
        bif.fall = 1'b0;
        e = exp_q.pop_front();
        check(nm, dut_out(), e);
    endtask

    function automatic logic [4:0] exp_at(input vec_t v, input int e);
        logic [4:0] x;
        x[4] = (e == v.short_a) || (e == v.short_b);
        x[3] = (e == v.dbl_e);
        x[2] = (e == v.long_e);
        x[1] = (e == v.rep_a) || (e == v.rep_b);
        x[0] = (e >= v.hold_lo) && (e < v.hold_hi);
        return x;
    endfunction

    task automatic pulse_reset(input string nm);
        // Asynchronous assertion mid-cycle, release before the next edge.
        reset_n = 1'b0;
        #2;
        check(nm, dut_out(), 5'b00000);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        //           ra rb  fa  fb  both ncyc sa  sb  dbl lng ra  rb  hlo hhi
        vecs[0] = '{0, -1,  3, -1, -1,  16,  8, -1, -1, -1, -1, -1, -1, -1}; // short
        vecs[1] = '{0,  8,  3, 12, -1,  20, -1, -1,  8, -1, -1, -1, -1, -1}; // double at gap boundary
        vecs[2] = '{0, -1, 18, -1, -1,  26, -1, -1, -1,  8, 12, 16,  8, 18}; // long + repeat
        vecs[3] = '{0, -1,  8, -1, -1,  18, 13, -1, -1, -1, -1, -1, -1, -1}; // long boundary
        vecs[4] = '{0, -1,  3, -1,  5,  14,  8, -1, -1, -1, -1, -1, -1, -1}; // rise+fall together
        vecs[5] = '{0,  4,  2, 20, -1,  26, -1, -1,  4, -1, -1, -1, -1, -1}; // second press not long
        vecs[6] = '{0,  9,  3, 10, -1,  20,  8, 15, -1, -1, -1, -1, -1, -1}; // gap expired, new press
        vecs[7] = '{0,  5,  6, -1, -1,  16, 11, -1, -1, -1, -1, -1, -1, -1}; // rise ignored in PRESS1

        bif.rise = 1'b0;
        bif.fall = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_state", dut_out(), 5'b00000);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            for (int e = 0; e < vecs[i].ncyc; e++) begin
                logic r;
                logic f;
                r = (e == vecs[i].rise_a) || (e == vecs[i].rise_b) || (e == vecs[i].both_e);
                f = (e == vecs[i].fall_a) || (e == vecs[i].fall_b) || (e == vecs[i].both_e);
                step($sformatf("vec%0d_e%0d", i, e), r, f, exp_at(vecs[i], e));
            end
        end

        // Reset taken mid-press: the later release must be ignored.
        step("rst_mid_rise", 1'b1, 1'b0, 5'b00000);
        for (int e = 1; e <= 4; e++) step("rst_mid_press", 1'b0, 1'b0, 5'b00000);
        pulse_reset("rst_mid_outputs");
        step("rst_mid_fall", 1'b0, 1'b1, 5'b00000);
        for (int e = 0; e < 12; e++) step("rst_mid_quiet", 1'b0, 1'b0, 5'b00000);
        // Fresh press afterwards behaves normally: short 8 edges after rise.
        step("rst_fresh_e0", 1'b1, 1'b0, 5'b00000);
        for (int e = 1; e <= 2; e++) step("rst_fresh_press", 1'b0, 1'b0, 5'b00000);
        step("rst_fresh_e3", 1'b0, 1'b1, 5'b00000);
        for (int e = 4; e <= 7; e++) step("rst_fresh_gap", 1'b0, 1'b0, 5'b00000);
        step("rst_fresh_short", 1'b0, 1'b0, 5'b10000);
        for (int e = 0; e < 3; e++) step("rst_fresh_idle", 1'b0, 1'b0, 5'b00000);

        // Reset while long-held must drop hold and stop repeats.
        step("rst_long_e0", 1'b1, 1'b0, 5'b00000);
        for (int e = 1; e <= 7; e++) step("rst_long_press", 1'b0, 1'b0, 5'b00000);
        step("rst_long_e8", 1'b0, 1'b0, 5'b00101);
        step("rst_long_e9", 1'b0, 1'b0, 5'b00001);
        pulse_reset("rst_long_outputs");
        for (int e = 0; e < 8; e++) step("rst_long_quiet", 1'b0, 1'b0, 5'b00000);
        step("rst_long_fall", 1'b0, 1'b1, 5'b00000);
        for (int e = 0; e < 8; e++) step("rst_long_after", 1'b0, 1'b0, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_gesture.md
# button_gesture

Classifies debounced button activity into short-press, double-press, long-press and auto-repeat events. Sits directly downstream of the debounce stage and consumes only its one-cycle `rise`/`fall` pulses. Each press emits exactly one gesture pulse. Downstream control logic (FT601 test-mode selection, manual transfer triggers) reacts only to these pulses and the `hold` level.

## Interface
- `LONG_COUNT`, default 50_000_000: clocks a press must last to count as long. Must be ≥ 2.
- `GAP_COUNT`, default 15_000_000: maximum release-to-press gap, in clocks, for a double press. Must be ≥ 2.
- `REPEAT_COUNT`, default 10_000_000: auto-repeat period in clocks while long-held. 0 disables repeat.
- `clock` input 1: sole clock. All logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `rise` input 1: one-cycle pulse from the debounce stage when the button is pressed.
- `fall` input 1: one-cycle pulse from the debounce stage when the button is released.
- `short_press` output 1: one-cycle pulse for a single short press.
- `double_press` output 1: one-cycle pulse for a second press inside the gap window.
- `long_press` output 1: one-cycle pulse when a press reaches `LONG_COUNT`.
- `repeat_press` output 1: one-cycle pulse every `REPEAT_COUNT` clocks while long-held.
- `hold` output 1: level, high from `long_press` until release.

## Operation
- Clock, reset and polarity:
  - One clock.
  - Reset is asynchronous, active-low.
  - All outputs are registered.
  - Reset value of every output is 0; state resets to IDLE and the counter to 0.
- One shared counter, sized with `$clog2` of the largest parameter plus 1.
  - Cleared on every state change.
  - Increments every cycle in PRESS1, WAIT_GAP and LONG_HELD.
  - Frozen at 0 in IDLE and PRESS2.
  - Never wraps: every terminal count forces a transition or a reload.
- States and transitions:
  - IDLE
    - `rise` → PRESS1.
    - `fall` is ignored. This covers a release seen after a reset taken mid-press.
  - PRESS1
    - `fall` → WAIT_GAP.
    - Counter reaches terminal with no `fall` → pulse `long_press`, set `hold`, go to LONG_HELD.
  - WAIT_GAP
    - `rise` → pulse `double_press`, go to PRESS2.
    - Counter reaches terminal with no `rise` → pulse `short_press`, go to IDLE.
  - PRESS2
    - `fall` → IDLE, with no pulse.
    - No long detection on the second press.
  - LONG_HELD
    - `fall` → clear `hold`, go to IDLE.
    - If `REPEAT_COUNT` > 0: counter reaches terminal → pulse `repeat_press` and reload the counter.
- Event rules:
  - An input event always wins over a timeout that lands on the same clock edge.
  - `rise` and `fall` asserted together is an upstream protocol error. Both are ignored and state is held.
  - A `rise` in PRESS1, PRESS2 or LONG_HELD, or a `fall` in WAIT_GAP, is ignored.
- At most one of the four event pulses is high in any cycle.

## Timing
All cycles are counted as clock edges, with the triggering input pulse sampled at edge 0.
- `long_press`: registered at edge `LONG_COUNT` after the `rise` edge, provided no `fall` was sampled at edges 1..`LONG_COUNT`.
  - `hold` rises on that same edge.
- `short_press`: registered at edge `GAP_COUNT` after the `fall` edge, provided no `rise` was sampled at edges 1..`GAP_COUNT`.
- `double_press`: registered on the same edge that samples the second `rise`.
  - Latency from that `rise` pulse is one register stage.
- `repeat_press`: registered at edges L+k·`REPEAT_COUNT` for k ≥ 1, where L is the `long_press` edge.
  - A `fall` sampled on a repeat edge suppresses that repeat.
- `hold` falls on the edge that samples `fall` in LONG_HELD.
- Reset deassertion: the block accepts `rise` from the first clock edge after `reset_n` goes high.

## Structure
- Shared package `button_pkg`:
  - State encoding localparams: IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD (3 bits).
  - Counter-width helper.
- No sub-module: one FSM plus one counter in a single module.
- The top-level wrapper instantiates the debounce stage followed by `button_gesture`.

## Test plan
All scenarios use `LONG_COUNT`=8, `GAP_COUNT`=5, `REPEAT_COUNT`=4, with `rise` at E0 unless stated.
- Short press: `fall` E3, nothing further → `short_press` at E8 only; state back in IDLE.
- Double press: `fall` E3, `rise` E8 (boundary) → `double_press` at E8. Then `fall` E12 → no further pulse.
- Long press with repeat: `rise` held, `fall` at E18 → `long_press` E8; `hold` high E8–E18; `repeat_press` at E12 and E16 only; no `short_press`.
- Long boundary: `fall` at E8 → no `long_press`; `short_press` at E13.
- Reset mid-press: pull `reset_n` low between E4 and E5, release, then `fall` pulse → all outputs 0 and no pulse. A fresh `rise`/`fall` pair afterwards gives a normal `short_press`.
- Protocol error: `rise` and `fall` together in WAIT_GAP → ignored; `short_press` still at its original edge.
